// File: rtl/instruction_fetch_controller.sv
// Instruction fetch sequencer: owns the PC, issues one imem request at a time,
// and hands each fetched word to decode over a valid/ready handshake.
module instruction_fetch_controller #(
  parameter int ADDR_WIDTH  = 8,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  output logic                   imem_req,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic                   instr_valid,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0]  instr_address,
  input  logic                   instr_ready,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_address,
  output logic [31:0]            fetched_count
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD
  } state_t;

  state_t                 r_state;
  logic [ADDR_WIDTH-1:0]  r_pc;
  logic                   r_imem_req;
  logic [ADDR_WIDTH-1:0]  r_imem_addr;
  logic                   r_instr_valid;
  logic [INSTR_WIDTH-1:0] r_instr;
  logic [ADDR_WIDTH-1:0]  r_instr_address;
  logic [31:0]            r_fetched_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= IDLE;
      r_pc            <= '0;
      r_imem_req      <= 1'b0;
      r_imem_addr     <= '0;
      r_instr_valid   <= 1'b0;
      r_instr         <= '0;
      r_instr_address <= '0;
      r_fetched_count <= '0;
    end else begin
      // A handshake still counts when a redirect lands in the same cycle.
      if (r_instr_valid && instr_ready) begin
        r_fetched_count <= r_fetched_count + 32'd1;
      end

      if (redirect_valid) begin
        // Abandons any outstanding request; same-cycle ack data is dropped.
        r_pc          <= redirect_address;
        r_imem_req    <= 1'b0;
        r_instr_valid <= 1'b0;
        r_state       <= IDLE;
      end else begin
        unique case (r_state)
          IDLE: begin
            if (enable) begin
              r_imem_req  <= 1'b1;
              r_imem_addr <= r_pc;
              r_state     <= FETCH;
            end
          end
          FETCH: begin
            if (imem_ack) begin
              r_instr         <= imem_rdata;
              r_instr_address <= r_pc;
              r_instr_valid   <= 1'b1;
              r_pc            <= r_pc + ADDR_WIDTH'(1);
              r_imem_req      <= 1'b0;
              r_state         <= HOLD;
            end
          end
          HOLD: begin
            if (instr_ready) begin
              r_instr_valid <= 1'b0;
              if (enable) begin
                r_imem_req  <= 1'b1;
                r_imem_addr <= r_pc;
                r_state     <= FETCH;
              end else begin
                r_state <= IDLE;
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign imem_req      = r_imem_req;
  assign imem_addr     = r_imem_addr;
  assign instr_valid   = r_instr_valid;
  assign instr         = r_instr;
  assign instr_address = r_instr_address;
  assign fetched_count = r_fetched_count;

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Bench for instruction_fetch_controller: directed timing scenarios followed by
// randomized traffic, all checked against a transaction-level reference.
module tb_instruction_fetch_controller;

  localparam int AW = 8;
  localparam int IW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [IW-1:0] imem_rdata;
  logic          instr_valid;
  logic [IW-1:0] instr;
  logic [AW-1:0] instr_address;
  logic          instr_ready;
  logic          redirect_valid;
  logic [AW-1:0] redirect_address;
  logic [31:0]   fetched_count;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  instruction_fetch_controller #(
    .ADDR_WIDTH (AW),
    .INSTR_WIDTH(IW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .instr_valid     (instr_valid),
    .instr           (instr),
    .instr_address   (instr_address),
    .instr_ready     (instr_ready),
    .redirect_valid  (redirect_valid),
    .redirect_address(redirect_address),
    .fetched_count   (fetched_count)
  );

  // Reference: address of the instruction decode should see next, number of
  // accepted handshakes, and the expected req/valid levels.
  logic [AW-1:0] exp_addr;
  logic [31:0]   hs_count;
  logic          m_req;
  logic          m_valid;

  bit            scramble;
  bit            rand_wait;
  bit            slow_en;
  logic [AW-1:0] slow_addr;
  int unsigned   slow_wait;
  bit            mem_busy;
  int unsigned   mem_left;
  int unsigned   cyc;

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    if (scramble) return (32'(a) * 32'h9E37_79B1) ^ 32'h0000_0100;
    return 32'(a) + 32'h100;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  // Memory responds to the current request, one clock edge elapses, the
  // reference is advanced from the driven inputs, and outputs are compared.
  task automatic run_cycle();
    logic hs;
    logic acc;
    if (imem_req === 1'b1) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        if (slow_en && imem_addr == slow_addr) mem_left = slow_wait;
        else mem_left = rand_wait ? $urandom_range(0, 3) : 0;
      end
      if (mem_left == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        mem_left--;
      end
    end else begin
      mem_busy   = 1'b0;
      imem_ack   = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
    end

    @(posedge clk);
    cyc++;
    if (rst) begin
      hs_count = '0;
      exp_addr = '0;
      m_req    = 1'b0;
      m_valid  = 1'b0;
    end else begin
      hs  = m_valid && instr_ready;
      acc = m_req && imem_ack && !redirect_valid;
      if (hs) hs_count++;
      m_req = !redirect_valid &&
              ((m_req && !imem_ack) ||
               (!m_req && !m_valid && enable) ||
               (m_valid && instr_ready && enable));
      m_valid = !redirect_valid && ((m_valid && !instr_ready) || acc);
      if (redirect_valid) exp_addr = redirect_address;
      else if (hs) exp_addr++;
    end
    #1;
    chk("count", fetched_count, hs_count);
    chk("req", 32'(imem_req), 32'(m_req));
    chk("valid", 32'(instr_valid), 32'(m_valid));
    if (m_req) chk("imem_addr", 32'(imem_addr), 32'(exp_addr));
    if (m_valid) begin
      chk("instr_address", 32'(instr_address), 32'(exp_addr));
      chk("instr", instr, mem_word(exp_addr));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run_cycle();
    rst = 1'b0;
  endtask

  initial begin
    logic [AW-1:0] got_a [2];
    int unsigned   n;
    bit            found;

    rst = 1'b1; enable = 1'b0; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_address = '0;
    imem_ack = 1'b0; imem_rdata = '0;
    scramble = 1'b0; rand_wait = 1'b0; slow_en = 1'b0; slow_addr = '0; slow_wait = 0;
    mem_busy = 1'b0; mem_left = 0; cyc = 0;
    exp_addr = '0; hs_count = '0; m_req = 1'b0; m_valid = 1'b0;

    // Reset state
    run_cycle();
    run_cycle();
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_address", 32'(instr_address), 32'h0);
    chk("rst_imem_addr", 32'(imem_addr), 32'h0);
    rst = 1'b0;

    // Streaming, zero-wait memory: four instructions in nine cycles
    enable = 1'b1; instr_ready = 1'b1;
    for (int i = 0; i < 9; i++) run_cycle();
    chk("stream_count", fetched_count, 32'd4);

    // Decode stall on address 2
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (instr_valid && instr_address == AW'(2)) begin found = 1'b1; break; end
      run_cycle();
    end
    chk("stall_reach", 32'(found), 32'd1);
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      run_cycle();
      chk("stall_req", 32'(imem_req), 32'd0);
      chk("stall_valid", 32'(instr_valid), 32'd1);
      chk("stall_addr", 32'(instr_address), 32'd2);
    end
    instr_ready = 1'b1;
    run_cycle();
    chk("stall_resume_req", 32'(imem_req), 32'd1);
    chk("stall_resume_addr", 32'(imem_addr), 32'd3);

    // Memory wait of 3 cycles on address 5
    slow_en = 1'b1; slow_addr = AW'(5); slow_wait = 3;
    n = 0; found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (imem_req && imem_addr == AW'(5)) n++;
      if (instr_valid && instr_address == AW'(5)) begin found = 1'b1; break; end
      run_cycle();
    end
    chk("wait_reach", 32'(found), 32'd1);
    chk("wait_req_cycles", n, 32'd4);
    slow_en = 1'b0;

    // Redirect to 0x40 in the same cycle as the ack for address 7
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (imem_req && imem_addr == AW'(7)) begin found = 1'b1; break; end
      run_cycle();
    end
    chk("redir_reach", 32'(found), 32'd1);
    redirect_valid = 1'b1; redirect_address = AW'(8'h40);
    run_cycle();
    redirect_valid = 1'b0;
    chk("redir_bubble_valid", 32'(instr_valid), 32'd0);
    chk("redir_bubble_req", 32'(imem_req), 32'd0);
    run_cycle();
    chk("redir_req", 32'(imem_req), 32'd1);
    chk("redir_addr", 32'(imem_addr), 32'h40);
    run_cycle();
    chk("redir_valid", 32'(instr_valid), 32'd1);
    chk("redir_iaddr", 32'(instr_address), 32'h40);

    // Wrap: redirect to all-ones while a handshake completes
    redirect_valid = 1'b1; redirect_address = '1;
    run_cycle();
    redirect_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (instr_valid && instr_ready) begin got_a[n] = instr_address; n++; end
      run_cycle();
      if (n == 2) break;
    end
    chk("wrap_n", n, 32'd2);
    chk("wrap_first", 32'(got_a[0]), 32'(AW'('1)));
    chk("wrap_second", 32'(got_a[1]), 32'd0);

    // Reset in HOLD with three completed handshakes, colliding with a redirect
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      run_cycle();
      if (hs_count == 32'd3) begin found = 1'b1; break; end
    end
    chk("hold_reach", 32'(found), 32'd1);
    instr_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (instr_valid) break;
      run_cycle();
    end
    chk("hold_valid", 32'(instr_valid), 32'd1);
    chk("hold_count", fetched_count, 32'd3);
    rst = 1'b1; redirect_valid = 1'b1; redirect_address = AW'(8'h33);
    run_cycle();
    rst = 1'b0; redirect_valid = 1'b0;
    chk("mid_rst_valid", 32'(instr_valid), 32'd0);
    chk("mid_rst_count", fetched_count, 32'd0);
    chk("mid_rst_req", 32'(imem_req), 32'd0);
    chk("mid_rst_iaddr", 32'(instr_address), 32'd0);
    chk("mid_rst_instr", instr, 32'd0);
    run_cycle();
    chk("mid_rst_pc_req", 32'(imem_req), 32'd1);
    chk("mid_rst_pc", 32'(imem_addr), 32'd0);

    // Randomized traffic with variable memory latency
    scramble = 1'b1; rand_wait = 1'b1;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      enable           = ($urandom_range(0, 9) != 0);
      instr_ready      = ($urandom_range(0, 2) != 0);
      redirect_valid   = ($urandom_range(0, 19) == 0);
      redirect_address = AW'($urandom);
      rst              = ($urandom_range(0, 299) == 0);
      run_cycle();
    end
    rst = 1'b0; redirect_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
